// File: rtl/pcm_pkg.sv
// Shared types and command words for the PCM burst reader.
package pcm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WR,
    CMD_REC,
    RD,
    RD_GAP,
    DONE
  } pcm_state_t;

  localparam logic [15:0] PCM_CMD_READ_ARRAY  = 16'h00FF;
  localparam logic [15:0] PCM_CMD_READ_STATUS = 16'h0070;
  localparam logic [15:0] PCM_CMD_CLR_STATUS  = 16'h0050;

endpackage

// File: rtl/pcm_wait_cnt.sv
// Loadable down-counter; o_zero marks the last cycle of a timed phase.
module pcm_wait_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pcm_burst_reader.sv
// Command write followed by a burst of word reads on the parallel PCM bus.
// Define PCM_PAGE_MODE_EN to read same-page words (addr[ADDR_W-1:2] unchanged) without a gap.
//
// state   | meaning
// IDLE    | bus inactive, waiting for start
// CMD_WR  | cs_n/we_n low, cmd driven on dq for WR_WAIT cycles
// CMD_REC | we_n released, dq still driven for one hold cycle
// RD      | cs_n/oe_n low; word captured on the last wait cycle
// RD_GAP  | cs_n/oe_n high between reads, address advanced
// DONE    | one-cycle done pulse
module pcm_burst_reader #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 8,
  parameter int WR_WAIT   = 6,
  parameter int RD_WAIT   = 10,
  parameter int GAP_CYC   = 1,
  parameter int PAGE_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              mem_cs_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i
);
  import pcm_pkg::*;

  localparam int CNT_W = 16;

  pcm_state_t        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_remaining;

  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_cnt_zero;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_page_hit;
  logic              w_last_rd;

  assign mem_rst_n   = 1'b1;
  assign w_next_addr = mem_addr + 1'b1;
  assign w_last_rd   = (r_remaining == LEN_W'(1));

`ifdef PCM_PAGE_MODE_EN
  assign w_page_hit = (w_next_addr[ADDR_W-1:2] == mem_addr[ADDR_W-1:2]);
`else
  assign w_page_hit = 1'b0;
`endif

  // Each timed phase loads N-1 on entry so it lasts exactly N cycles.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(WR_WAIT - 1);
        end
      end
      CMD_REC: begin
        if (r_len != '0) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(RD_WAIT - 1);
        end
      end
      RD: begin
        if (w_cnt_zero && !w_last_rd) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = w_page_hit ? CNT_W'(PAGE_WAIT - 1) : CNT_W'(GAP_CYC - 1);
        end
      end
      RD_GAP: begin
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = CNT_W'(RD_WAIT - 1);
        end
      end
      default: begin
      end
    endcase
  end

  pcm_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_val),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      mem_cs_n    <= 1'b1;
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_addr    <= '0;
      mem_dq_o    <= '0;
      mem_dq_oe   <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base    <= base_addr;
            r_len     <= len;
            busy      <= 1'b1;
            mem_cs_n  <= 1'b0;
            mem_we_n  <= 1'b0;
            mem_dq_oe <= 1'b1;
            mem_addr  <= cmd_addr;
            mem_dq_o  <= cmd;
            r_state   <= CMD_WR;
          end
        end
        CMD_WR: begin
          if (w_cnt_zero) begin
            mem_cs_n <= 1'b1;
            mem_we_n <= 1'b1;
            r_state  <= CMD_REC;
          end
        end
        CMD_REC: begin
          mem_dq_oe <= 1'b0;
          if (r_len == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else begin
            mem_addr    <= r_base;
            r_remaining <= r_len;
            mem_cs_n    <= 1'b0;
            mem_oe_n    <= 1'b0;
            r_state     <= RD;
          end
        end
        RD: begin
          if (w_cnt_zero) begin
            rd_data     <= mem_dq_i;
            rd_valid    <= 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (w_last_rd) begin
              mem_cs_n <= 1'b1;
              mem_oe_n <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              r_state  <= DONE;
            end else if (w_page_hit) begin
              // same page: keep the device enabled and just move the address
              mem_addr <= w_next_addr;
            end else begin
              mem_cs_n <= 1'b1;
              mem_oe_n <= 1'b1;
              mem_addr <= w_next_addr;
              r_state  <= RD_GAP;
            end
          end
        end
        RD_GAP: begin
          if (w_cnt_zero) begin
            mem_cs_n <= 1'b0;
            mem_oe_n <= 1'b0;
            r_state  <= RD;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_burst_reader.sv
// Scoreboard bench for pcm_burst_reader; expectations come from a cycle-count model of a request.
module tb_pcm_burst_reader;
  import pcm_pkg::*;

  localparam int ADDR_W    = 24;
  localparam int DATA_W    = 16;
  localparam int LEN_W     = 8;
  localparam int WR_WAIT   = 6;
  localparam int RD_WAIT   = 10;
  localparam int GAP_CYC   = 1;
  localparam int PAGE_WAIT = 3;
`ifdef PCM_PAGE_MODE_EN
  localparam bit PAGE_EN = 1'b1;
`else
  localparam bit PAGE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] cmd = '0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              busy, done, rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              mem_cs_n, mem_oe_n, mem_we_n, mem_rst_n, mem_dq_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dq_o;
  logic [DATA_W-1:0] mem_dq_i;

  typedef struct {int cyc; logic [DATA_W-1:0] data;} rd_exp_t;
  typedef struct {int cyc; logic [DATA_W-1:0] cmd; logic [ADDR_W-1:0] addr;} cmd_exp_t;

  rd_exp_t  rd_q[$];
  cmd_exp_t cmd_q[$];
  int       done_q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int busy_start = 0;
  int busy_end = 0;
  int idle_from = 0;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[23:16], ~a[23:16]} ^ 16'h3C5A;
  endfunction

  // Memory only answers while selected and output-enabled.
  assign mem_dq_i = (!mem_cs_n && !mem_oe_n) ? mem_word(mem_addr) : 16'hDEAD;

  pcm_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .WR_WAIT(WR_WAIT),
    .RD_WAIT(RD_WAIT), .GAP_CYC(GAP_CYC), .PAGE_WAIT(PAGE_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .cmd_addr(cmd_addr),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .mem_cs_n(mem_cs_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_rst_n(mem_rst_n),
    .mem_addr(mem_addr), .mem_dq_o(mem_dq_o), .mem_dq_oe(mem_dq_oe),
    .mem_dq_i(mem_dq_i)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: a request is a timeline of phase lengths added up from the start cycle.
  task automatic model_accept(input int t0, input logic [DATA_W-1:0] c,
                              input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] b,
                              input logic [LEN_W-1:0] l);
    int t;
    int d;
    logic [ADDR_W-1:0] a, prev;
    bit hit;
    cmd_q.push_back('{t0 + 1, c, ca});
    t = t0 + WR_WAIT + 2;
    prev = b;
    for (int i = 0; i < int'(l); i++) begin
      a = ADDR_W'(b + ADDR_W'(i));
      hit = PAGE_EN && (i > 0) && (a[ADDR_W-1:2] == prev[ADDR_W-1:2]);
      if (i > 0 && !hit) t += GAP_CYC;
      t += hit ? PAGE_WAIT : RD_WAIT;
      rd_q.push_back('{t, mem_word(a)});
      prev = a;
    end
    d = (l == '0) ? t0 + WR_WAIT + 2 : t;
    done_q.push_back(d);
    busy_start = t0 + 1;
    busy_end   = d;
    idle_from  = d + 1;
  endtask

  // Called at a falling edge; holds start for one cycle.
  task automatic issue(input logic [DATA_W-1:0] c, input logic [ADDR_W-1:0] ca,
                       input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l,
                       output bit acc, output int t0);
    start = 1'b1; cmd = c; cmd_addr = ca; base_addr = b; len = l;
    t0  = cyc;
    acc = (cyc >= idle_from);
    if (acc) model_accept(t0, c, ca, b, l);
    @(negedge clk);
    start = 1'b0;
    cmd = DATA_W'($urandom); cmd_addr = ADDR_W'($urandom);
    base_addr = ADDR_W'($urandom); len = LEN_W'($urandom);
  endtask

  task automatic issue_rand();
    bit acc;
    int t0;
    logic [DATA_W-1:0] c;
    logic [ADDR_W-1:0] b;
    case ($urandom_range(0, 3))
      0: c = PCM_CMD_READ_ARRAY;
      1: c = PCM_CMD_READ_STATUS;
      2: c = PCM_CMD_CLR_STATUS;
      default: c = DATA_W'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) b = {22'h3FFFFF, 2'($urandom)};
    else b = ADDR_W'($urandom);
    issue(c, ADDR_W'($urandom), b, LEN_W'($urandom_range(0, 6)), acc, t0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cyc < idle_from || rd_q.size() != 0 || done_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("idle_timeout_pending", 32'(rd_q.size() + done_q.size()), 32'(0));
      rd_q.delete();
      done_q.delete();
      idle_from = cyc;
    end
  endtask

  // Monitor: compares every observed pulse and bus cycle against the queued expectations.
  initial begin
    rd_exp_t  re;
    cmd_exp_t ce;
    int       de;
    logic     we_prev;
    int       we_run;
    logic [DATA_W-1:0] cur_cmd;
    we_prev = 1'b1;
    we_run  = 0;
    cur_cmd = '0;
    forever begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(cyc >= busy_start && cyc < busy_end));

      while (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
        chk("rd_missing_due", 32'(cyc), 32'(rd_q[0].cyc));
        void'(rd_q.pop_front());
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'(0));
        else begin
          re = rd_q.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(re.cyc));
          chk("rd_data", 32'(rd_data), 32'(re.data));
        end
      end

      while (done_q.size() != 0 && done_q[0] < cyc) begin
        chk("done_missing_due", 32'(cyc), 32'(done_q[0]));
        void'(done_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(done), 32'(0));
        else begin
          de = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(de));
        end
      end

      if (!mem_we_n) begin
        if (we_prev) begin
          if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(mem_we_n), 32'(1));
          else begin
            ce = cmd_q.pop_front();
            chk("cmd_cycle", 32'(cyc), 32'(ce.cyc));
            chk("cmd_addr", 32'(mem_addr), 32'(ce.addr));
            cur_cmd = ce.cmd;
          end
          we_run = 0;
        end
        we_run++;
        chk("cmd_dq_oe", 32'(mem_dq_oe), 32'(1));
        chk("cmd_cs_n", 32'(mem_cs_n), 32'(0));
        chk("cmd_oe_n", 32'(mem_oe_n), 32'(1));
        chk("cmd_dq_o", 32'(mem_dq_o), 32'(cur_cmd));
      end else if (!we_prev) begin
        chk("we_low_len", 32'(we_run), 32'(WR_WAIT));
      end
      we_prev = mem_we_n;
    end
  end

  initial begin
    bit acc;
    int t0;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(mem_cs_n), 32'(1));
    chk("rst_oe_n", 32'(mem_oe_n), 32'(1));
    chk("rst_we_n", 32'(mem_we_n), 32'(1));
    chk("rst_dq_oe", 32'(mem_dq_oe), 32'(0));
    chk("rst_dq_o", 32'(mem_dq_o), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("mem_rst_n", 32'(mem_rst_n), 32'(1));
    rst = 1'b0;
    idle_from = cyc;

    issue(PCM_CMD_READ_ARRAY, 24'h100000, 24'h100000, 8'd1, acc, t0);
    chk("accept_first", 32'(acc), 32'(1));
    wait_idle();

    issue(PCM_CMD_READ_ARRAY, 24'h000000, 24'hFFFFFE, 8'd4, acc, t0);
    wait_idle();

    issue(PCM_CMD_READ_STATUS, 24'h000123, 24'h000040, 8'd0, acc, t0);
    wait_idle();

    issue(PCM_CMD_CLR_STATUS, 24'h0000AA, 24'h001000, 8'd3, acc, t0);
    repeat (60) begin
      if ($urandom_range(0, 2) == 0) issue_rand();
      else @(negedge clk);
    end
    wait_idle();

    issue(PCM_CMD_READ_ARRAY, 24'h000010, 24'h000200, 8'd5, acc, t0);
    while (cyc < t0 + WR_WAIT + 4) @(negedge clk);
    rst = 1'b1;
    rd_q.delete();
    done_q.delete();
    busy_end  = cyc + 1;
    idle_from = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_cs_n", 32'(mem_cs_n), 32'(1));
    chk("midrst_oe_n", 32'(mem_oe_n), 32'(1));
    chk("midrst_we_n", 32'(mem_we_n), 32'(1));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_dq_oe", 32'(mem_dq_oe), 32'(0));
    repeat (20) @(negedge clk);

    issue(PCM_CMD_READ_ARRAY, 24'h000000, 24'h000002, 8'd4, acc, t0);
    chk("accept_after_rst", 32'(acc), 32'(1));
    wait_idle();

    for (int k = 0; k < 20; k++) begin
      issue_rand();
      n = 0;
      while (n < 120 && (cyc < idle_from + 2)) begin
        if ($urandom_range(0, 4) == 0) issue_rand();
        else @(negedge clk);
        n++;
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queues_drained", 32'(rd_q.size() + done_q.size() + cmd_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
